// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: redirect, instruction-memory and decode-side signals.
// The master modport is the core/environment side; the slave modport is the
// fetch_queue itself. Optional macro FETCH_QUEUE_PERF_EN adds bubble_cnt.
interface fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] pc_f;
    logic            imem_ready;
    logic [31:0]     imem_rdata;
    logic            stall_d;
    logic            valid_d;
    logic [31:0]     instr_d;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_plus4_d;
    logic            full_f;
    logic [CW-1:0]   count_f;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0]     bubble_cnt;

    modport master (
        output redirect_valid, redirect_pc, imem_ready, imem_rdata, stall_d,
        input  pc_f, valid_d, instr_d, pc_d, pc_plus4_d, full_f, count_f, bubble_cnt
    );

    modport slave (
        input  redirect_valid, redirect_pc, imem_ready, imem_rdata, stall_d,
        output pc_f, valid_d, instr_d, pc_d, pc_plus4_d, full_f, count_f, bubble_cnt
    );
`else
    modport master (
        output redirect_valid, redirect_pc, imem_ready, imem_rdata, stall_d,
        input  pc_f, valid_d, instr_d, pc_d, pc_plus4_d, full_f, count_f
    );

    modport slave (
        input  redirect_valid, redirect_pc, imem_ready, imem_rdata, stall_d,
        output pc_f, valid_d, instr_d, pc_d, pc_plus4_d, full_f, count_f
    );
`endif
endinterface

// File: rtl/fetch_queue.sv
// Fetch stage with an instruction prefetch queue. Fetches sequentially from
// pc_q into a DEPTH-entry circular buffer of {instr, pc, pc+4}; decode reads
// the head. A redirect flushes the queue and reloads the PC.
// Optional macro FETCH_QUEUE_PERF_EN adds a saturating bubble counter.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    fetch_queue_if.slave bus
);
    localparam int          AW  = $clog2(DEPTH);
    localparam int          CW  = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Queue storage
    logic [31:0]     instr_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q    [DEPTH];
    logic [XLEN-1:0] pc4_mem_q   [DEPTH];

    // Control state
    logic [XLEN-1:0] pc_q,     pc_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;

    logic            full;
    logic            empty;
    logic            enq;
    logic            deq;
    logic [XLEN-1:0] pc_next_seq;

    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    assign enq         = bus.imem_ready & ~full & ~bus.redirect_valid;
    assign deq         = ~empty & ~bus.stall_d & ~bus.redirect_valid;
    assign pc_next_seq = pc_q + XLEN'(4);

    // Next-state selection: redirect overrides any enqueue/dequeue this cycle
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.redirect_valid) begin
            pc_d     = bus.redirect_pc;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                pc_d     = pc_next_seq;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(enq) - CW'(deq);
        end
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue write port; suppressed during reset
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; stale entries are never visible because count gates the head outputs.
        if (!rst && enq) begin
            instr_mem_q[wr_ptr_q] <= bus.imem_rdata;
            pc_mem_q[wr_ptr_q]    <= pc_q;
            pc4_mem_q[wr_ptr_q]   <= pc_next_seq;
        end
    end

    // Head presentation: combinational read of the head entry, NOP/0 when empty
    always_comb begin
        bus.pc_f       = pc_q;
        bus.valid_d    = ~empty;
        bus.full_f     = full;
        bus.count_f    = count_q;
        bus.instr_d    = NOP;
        bus.pc_d       = '0;
        bus.pc_plus4_d = '0;
        if (!empty) begin
            bus.instr_d    = instr_mem_q[rd_ptr_q];
            bus.pc_d       = pc_mem_q[rd_ptr_q];
            bus.pc_plus4_d = pc4_mem_q[rd_ptr_q];
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] bubble_cnt_q;

    // Saturating count of cycles in which decode saw no valid instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else if (empty && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign bus.bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a directed table, hand-written corner
// sequences and randomized traffic, all compared against a queue-based model.
module tb_fetch_queue;
    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: plain queues of fetched entries plus the fetch PC
    logic [31:0] m_pc = RESET_PC;
    logic [31:0] m_ins [$];
    logic [31:0] m_pcs [$];
    logic [31:0] m_bub = '0;

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic        stall;
        logic        e_valid;
        logic [31:0] e_pc_f;
        logic [31:0] e_pc_d;
        int          e_count;
        logic        e_full;
    } vec_t;

    vec_t tbl [14];

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic rv, input logic [31:0] rp,
                              input logic rdy, input logic st);
        int sz = m_pcs.size();
        if (r) m_bub = '0;
        else if (sz == 0 && m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 1;
        if (r) begin
            m_pc = RESET_PC;
            m_ins.delete();
            m_pcs.delete();
        end else if (rv) begin
            m_pc = rp;
            m_ins.delete();
            m_pcs.delete();
        end else begin
            if (sz > 0 && !st) begin
                void'(m_ins.pop_front());
                void'(m_pcs.pop_front());
            end
            if (rdy && sz != DEPTH) begin
                m_ins.push_back(mem_fn(m_pc));
                m_pcs.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic compare_model();
        int sz = m_pcs.size();
        check("pc_f", bus.pc_f, m_pc);
        check("valid_d", 32'(bus.valid_d), 32'(sz != 0));
        check("instr_d", bus.instr_d, (sz != 0) ? m_ins[0] : 32'h0000_0013);
        check("pc_d", bus.pc_d, (sz != 0) ? m_pcs[0] : 32'h0);
        check("pc_plus4_d", bus.pc_plus4_d, (sz != 0) ? m_pcs[0] + 32'd4 : 32'h0);
        check("count_f", 32'(bus.count_f), 32'(sz));
        check("full_f", 32'(bus.full_f), 32'(sz == DEPTH));
`ifdef FETCH_QUEUE_PERF_EN
        check("bubble_cnt", bus.bubble_cnt, m_bub);
`endif
    endtask

    // Drive one cycle of inputs, clock it, advance the model, compare after the edge
    task automatic apply(input logic r, input logic rv, input logic [31:0] rp,
                         input logic rdy, input logic st);
        rst                = r;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
        bus.imem_ready     = rdy;
        bus.imem_rdata     = mem_fn(m_pc);
        bus.stall_d        = st;
        @(posedge clk);
        model_step(r, rv, rp, rdy, st);
        #1;
        compare_model();
    endtask

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_ready     = 1'b0;
        bus.imem_rdata     = '0;
        bus.stall_d        = 1'b0;

        // rst redir rpc ready stall | valid pc_f pc_d count full
        tbl[0]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h100, 32'h0,   0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h100, 32'h0,   0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h104, 32'h100, 1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h108, 32'h100, 2, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h10C, 32'h100, 3, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h110, 32'h100, 4, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h110, 32'h100, 4, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h110, 32'h104, 3, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h110, 32'h108, 2, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h114, 32'h10C, 2, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0,   0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h204, 32'h200, 1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h204, 32'h0,   0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h208, 32'h204, 1, 1'b0};

        for (int i = 0; i < 14; i++) begin
            apply(tbl[i].rst, tbl[i].redir, tbl[i].rpc, tbl[i].ready, tbl[i].stall);
            check($sformatf("tbl%0d.valid", i), 32'(bus.valid_d), 32'(tbl[i].e_valid));
            check($sformatf("tbl%0d.pc_f", i), bus.pc_f, tbl[i].e_pc_f);
            check($sformatf("tbl%0d.pc_d", i), bus.pc_d, tbl[i].e_pc_d);
            check($sformatf("tbl%0d.count", i), 32'(bus.count_f), 32'(tbl[i].e_count));
            check($sformatf("tbl%0d.full", i), 32'(bus.full_f), 32'(tbl[i].e_full));
        end

        // Streaming: one instruction per cycle, occupancy steady at 1
        for (int i = 0; i < 6; i++) begin
            apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
            check("stream.count", 32'(bus.count_f), 32'd1);
            check("stream.pc_d", bus.pc_d, 32'h208 + 32'(4 * i));
        end

        // PC wrap at the top of the address space
        apply(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
        apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("wrap.pc_d", bus.pc_d, 32'hFFFF_FFFC);
        check("wrap.pc_plus4_d", bus.pc_plus4_d, 32'h0);
        check("wrap.pc_f", bus.pc_f, 32'h0);
        apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("wrap.pc_f2", bus.pc_f, 32'h4);
        check("wrap.count", 32'(bus.count_f), 32'd2);

        // Reset in the middle of operation
        apply(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        check("midrst.pc_f", bus.pc_f, RESET_PC);
        check("midrst.count", 32'(bus.count_f), 32'd0);
        check("midrst.instr", bus.instr_d, 32'h0000_0013);

`ifdef FETCH_QUEUE_PERF_EN
        apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("perf.idle5", bus.bubble_cnt, 32'd5);
        apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("perf.fill", bus.bubble_cnt, 32'd6);
        apply(1'b0, 1'b1, 32'h300, 1'b1, 1'b1);
        apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        apply(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("perf.redirect", bus.bubble_cnt, 32'd7);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            logic r, rv, rdy, st;
            logic [31:0] rp;
            r   = ($urandom_range(0, 99) < 1);
            rv  = ($urandom_range(0, 99) < 5);
            rp  = $urandom() & 32'hFFFF_FFFC;
            rdy = ($urandom_range(0, 99) < 70);
            st  = ($urandom_range(0, 99) < 40);
            apply(r, rv, rp, rdy, st);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
